// File: rtl/i2c_fnd_mux_slave.sv
// I2C slave with pointer-addressed digit registers driving a
// time-multiplexed common-anode 7-segment display.
module i2c_fnd_mux_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h56,
    parameter int         NUM_DIGITS = 4,
    parameter int         SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  debug_addr_match,
    output logic [3:0]            debug_state
);

    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PTR_MAX = PW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [7:0]    NUM_B   = 8'(NUM_DIGITS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic [2:0]    scl_sync_q, scl_sync_d;
    logic [2:0]    sda_sync_q, sda_sync_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          match_q, match_d;
    logic [7:0]    regs_q [NUM_DIGITS];
    logic [7:0]    regs_d [NUM_DIGITS];
    logic [CW-1:0] scan_q, scan_d;
    logic [PW-1:0] idx_q, idx_d;

    logic scl_rise, scl_fall, sda_in, start_c, stop_c;
    logic [PW-1:0] ptr_inc;
    logic [7:0]    cur_reg;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Synchroniser shift and edge/condition detection on the synced pins
    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl};
        sda_sync_d = {sda_sync_q[1:0], sda};
        scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
        sda_in   = sda_sync_q[1];
        start_c  = scl_sync_q[1] & scl_sync_q[2]
                 & ~sda_sync_q[1] & sda_sync_q[2];
        stop_c   = scl_sync_q[1] & scl_sync_q[2]
                 & sda_sync_q[1] & ~sda_sync_q[2];
        ptr_inc  = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
        cur_reg  = regs_q[ptr_q];
    end

    // Bus protocol FSM: next-state, pointer and register file updates
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        match_d   = match_q;
        regs_d    = regs_q;
        if (start_c) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            match_d   = 1'b0;
        end else if (stop_c && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            match_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_in};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d = S_ADDR_ACK;
                                match_d = 1'b1;
                                rw_d    = sda_in;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_in};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            state_d   = (state_q == S_PTR) ? S_PTR_ACK
                                                           : S_WR_ACK;
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR_ACK) begin
                                if (rw_q) begin
                                    state_d   = S_RD_DATA;
                                    shift_d   = cur_reg;
                                    sda_oe_d  = ~cur_reg[7];
                                    bit_cnt_d = 4'd1;
                                end else begin
                                    state_d = S_PTR;
                                end
                            end else if (state_q == S_PTR_ACK) begin
                                ptr_d   = (shift_q < NUM_B) ? shift_q[PW-1:0]
                                                            : '0;
                                state_d = S_WR_DATA;
                            end else begin
                                regs_d[ptr_q] = shift_q;
                                ptr_d         = ptr_inc;
                                state_d       = S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_in) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            ptr_d     = ptr_inc;
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = S_RD_DATA;
                        shift_d   = cur_reg;
                        sda_oe_d  = ~cur_reg[7];
                        bit_cnt_d = 4'd1;
                    end
                end
                S_IDLE, S_WAIT_STOP: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Display scan counter and digit index
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == CNT_MAX) begin
            scan_d = '0;
            idx_d  = (idx_q == PTR_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Input synchronisers carry no reset so a reset cannot fake a bus edge
    always_ff @(posedge clk) begin
        scl_sync_q <= scl_sync_d;
        sda_sync_q <= sda_sync_d;
    end

    // Protocol, register file and scan state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            match_q   <= 1'b0;
            regs_q    <= '{default: 8'h00};
            scan_q    <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            match_q   <= match_d;
            regs_q    <= regs_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
        end
    end

    assign sda = sda_oe_q ? 1'b0 : 1'bz;
    assign an  = ~(NUM_DIGITS'(1) << idx_q);
    assign seg = regs_q[idx_q][7] ? 7'h7F : glyph(regs_q[idx_q][3:0]);
    assign debug_addr_match = match_q;
    assign debug_state      = state_q;

endmodule

// File: tb/tb_i2c_fnd_mux_slave.sv
// Bench for i2c_fnd_mux_slave: bit-banged I2C master, transaction-level
// register/pointer model, and a per-cycle display compare.
module tb_i2c_fnd_mux_slave;

    localparam int ND = 4;
    localparam int SD = 16;
    localparam int Q  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          dam;
    logic [3:0]    dst;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_fnd_mux_slave #(
        .SLAVE_ADDR(7'h56),
        .NUM_DIGITS(ND),
        .SCAN_DIV(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scl(m_scl),
        .sda(sda),
        .seg(seg),
        .an(an),
        .debug_addr_match(dam),
        .debug_state(dst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hold_until = 0;
    bit chk_en = 0;
    bit watch_z = 0;
    logic [7:0] mregs [ND];
    int mptr = 0;
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] exp_seg(input logic [7:0] r);
        return r[7] ? 7'h7F : GLYPH[r[3:0]];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin : cmp
        int i;
        logic [ND-1:0] ea;
        if (chk_en && !rst) begin
            i  = (cyc / SD) % ND;
            ea = ~(ND'(1) << i);
            check("an_scan", int'(an), int'(ea));
            if (cyc >= hold_until)
                check("seg_scan", int'(seg), int'(exp_seg(mregs[i])));
            if (watch_z && !m_low)
                check("sda_released", int'(sda), 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; m_scl = 1'b1; tick(Q);
        m_low = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        m_low = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_low = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_low = 1'b0; tick(2 * Q);
    endtask

    task automatic bit_tx(input logic b);
        m_low = ~b; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bit_rx(output logic r);
        m_low = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        r = sda; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) bit_tx(b[i]);
        bit_rx(a);
    endtask

    task automatic read_byte(output logic [7:0] d, input bit ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_rx(r);
            d[i] = r;
        end
        bit_tx(ack ? 1'b0 : 1'b1);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        mptr = (p < ND) ? int'(p) : 0;
    endtask

    task automatic txn_write(input logic [7:0] p, input int n);
        logic a;
        i2c_start();
        write_byte(8'hAC, a); check("ack_addr_w", a, 0);
        write_byte(p, a);     check("ack_ptr", a, 0);
        set_ptr(p);
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) bit_tx(wbuf[k][i]);
            hold_until = cyc + 40;
            mregs[mptr] = wbuf[k];
            mptr = (mptr + 1) % ND;
            bit_rx(a);
            check("ack_data", a, 0);
        end
        i2c_stop();
    endtask

    task automatic txn_read(input bit setp, input logic [7:0] p,
                            input int n);
        logic a;
        logic [7:0] d;
        i2c_start();
        if (setp) begin
            write_byte(8'hAC, a); check("ack_addr_w", a, 0);
            write_byte(p, a);     check("ack_ptr", a, 0);
            set_ptr(p);
            i2c_rstart();
        end
        write_byte(8'hAD, a); check("ack_addr_r", a, 0);
        for (int k = 0; k < n; k++) begin
            read_byte(d, k < n - 1);
            check("rd_data", int'(d), int'(mregs[mptr]));
            rbuf[k] = d;
            if (k < n - 1) mptr = (mptr + 1) % ND;
        end
        i2c_stop();
    endtask

    task automatic txn_bad(input logic [7:0] ab, input int n);
        logic a;
        watch_z = 1'b1;
        i2c_start();
        write_byte(ab, a); check("nack_addr", a, 1);
        check("addr_match_low", dam, 0);
        for (int k = 0; k < n; k++) begin
            write_byte(8'($urandom_range(0, 255)), a);
            check("nack_data", a, 1);
        end
        i2c_stop();
        watch_z = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        int k;
        k = 0;
        @(negedge clk);
        while (!(((cyc / SD) % ND) == d && cyc >= hold_until) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("wait_digit_bound", int'(k < 400), 1);
    endtask

    initial begin : watchdog
        #900us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic a;
        logic [7:0] b;
        logic [6:0] a7;
        for (int i = 0; i < ND; i++) mregs[i] = 8'h00;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_an", int'(an), 4'b1110);
        check("rst_seg", int'(seg), 7'h40);
        check("rst_state", int'(dst), 0);
        check("rst_match", int'(dam), 0);
        check("rst_sda", int'(sda), 1);
        repeat (SD) @(negedge clk);
        check("scan_step1", int'(an), 4'b1101);

        wbuf[0] = 8'h05; wbuf[1] = 8'h8A; wbuf[2] = 8'h0F;
        txn_write(8'h01, 3);
        txn_read(1'b0, 8'h00, 1);
        check("reg0_unchanged_ptr_wrap", int'(rbuf[0]), 8'h00);
        wait_digit(2);
        check("blank_digit2", int'(seg), 7'h7F);
        wait_digit(3);
        check("digit3_F", int'(seg), 7'h0E);

        txn_read(1'b1, 8'h01, 3);
        check("rd_lit0", int'(rbuf[0]), 8'h05);
        check("rd_lit1", int'(rbuf[1]), 8'h8A);
        check("rd_lit2", int'(rbuf[2]), 8'h0F);
        check("idle_after_read", int'(dst), 0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        txn_write(8'h03, 2);
        wbuf[0] = 8'h07;
        txn_write(8'h09, 1);
        txn_read(1'b1, 8'h00, 4);
        check("wrap_reg0", int'(rbuf[0]), 8'h07);
        check("wrap_reg3", int'(rbuf[3]), 8'h11);

        txn_bad(8'hAE, 2);

        i2c_start();
        write_byte(8'hAC, a); check("ack_addr_rst", a, 0);
        write_byte(8'h01, a); check("ack_ptr_rst", a, 0);
        b = 8'h5A;
        for (int i = 7; i >= 5; i--) bit_tx(b[i]);
        m_low = ~b[4]; tick(Q);
        m_scl = 1'b1; tick(Q);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < ND; i++) mregs[i] = 8'h00;
        mptr = 0;
        hold_until = 0;
        check("rst_mid_sda", int'(sda), 1);
        check("rst_mid_state", int'(dst), 0);
        check("rst_mid_match", int'(dam), 0);
        tick(Q);
        m_scl = 1'b0; tick(Q);
        i2c_stop();
        txn_read(1'b1, 8'h00, 4);
        for (int i = 0; i < 4; i++)
            check("post_rst_reg", int'(rbuf[i]), 8'h00);

        for (int t = 0; t < 14; t++) begin
            int kind, n;
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 5);
            if (kind == 0) begin
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
                txn_write(8'($urandom_range(0, 9)), n);
            end else if (kind == 1) begin
                txn_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), n);
            end else begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h56) a7 = 7'h57;
                txn_bad({a7, 1'($urandom_range(0, 1))}, n);
            end
        end
        txn_read(1'b1, 8'h00, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
